// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and load (B) writeback.
// Writes to register 0 complete their handshake but are never issued. They are counted in drop_cnt.
module rf_wb_arbiter #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          a_valid,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_reg,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic [AW-1:0] rf_writereg,
    output logic [DW-1:0] rf_writedata,
    output logic          rf_regwrite,
    output logic          last_grant,
    output logic [CW-1:0] drop_cnt
);

    localparam logic [CW-1:0] DROP_MAX = '1;

    logic          ptr_q;
    logic          grant_a_c;
    logic          grant_b_c;
    logic          grant_c;
    logic [AW-1:0] sel_reg_c;
    logic [DW-1:0] sel_data_c;

    // Ready depends only on the other requester and the pointer, never on its own valid.
    // Reset masks both readies so that no handshake completes in a reset cycle.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst && !freeze) begin
            a_ready = !b_valid || !ptr_q;
            b_ready = !a_valid || ptr_q;
        end
    end

    always_comb begin
        grant_a_c  = a_valid && a_ready;
        grant_b_c  = b_valid && b_ready;
        grant_c    = grant_a_c || grant_b_c;
        sel_reg_c  = a_reg;
        sel_data_c = a_data;
        if (grant_b_c) begin
            sel_reg_c  = b_reg;
            sel_data_c = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            last_grant   <= 1'b1;
            rf_writereg  <= '0;
            rf_writedata <= '0;
            rf_regwrite  <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            rf_regwrite <= 1'b0;
            if (grant_c) begin
                rf_writereg  <= sel_reg_c;
                rf_writedata <= sel_data_c;
                rf_regwrite  <= (sel_reg_c != '0);
                ptr_q        <= grant_a_c;
                last_grant   <= grant_b_c;
                if (sel_reg_c == '0 && drop_cnt != DROP_MAX) begin
                    drop_cnt <= drop_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter. A second instance with CW=2 shares the stimulus and checks drop_cnt saturation.
module tb_rf_wb_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze;
    logic          a_valid;
    logic [AW-1:0] a_reg;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic [AW-1:0] b_reg;
    logic [DW-1:0] b_data;

    logic          a_ready, b_ready, rf_regwrite, last_grant;
    logic [AW-1:0] rf_writereg;
    logic [DW-1:0] rf_writedata;
    logic [7:0]    drop_cnt;

    logic          s_a_ready, s_b_ready, s_regwrite, s_last_grant;
    logic [AW-1:0] s_writereg;
    logic [DW-1:0] s_writedata;
    logic [1:0]    s_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.AW(AW), .DW(DW), .CW(8)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .rf_writereg(rf_writereg), .rf_writedata(rf_writedata), .rf_regwrite(rf_regwrite),
        .last_grant(last_grant), .drop_cnt(drop_cnt)
    );

    rf_wb_arbiter #(.AW(AW), .DW(DW), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .freeze(freeze),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(s_b_ready),
        .rf_writereg(s_writereg), .rf_writedata(s_writedata), .rf_regwrite(s_regwrite),
        .last_grant(s_last_grant), .drop_cnt(s_drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int unsigned exp_reg [6] = '{1, 11, 2, 12, 3, 13};
    logic        exp_a   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int ai;
        int bi;
        freeze = 1'b0;
        a_reg = '0; a_data = '0; b_reg = '0; b_data = '0;
        do_reset();

        // Reset state
        check("rst_regwrite", 64'(rf_regwrite), 64'd0);
        check("rst_writereg", 64'(rf_writereg), 64'd0);
        check("rst_writedata", 64'(rf_writedata), 64'd0);
        check("rst_last_grant", 64'(last_grant), 64'd1);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Single A write
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h1234;
        #1;
        check("t1_a_ready", 64'(a_ready), 64'd1);
        check("t1_b_ready", 64'(b_ready), 64'd0);
        tick();
        a_valid = 1'b0;
        check("t1_regwrite", 64'(rf_regwrite), 64'd1);
        check("t1_writereg", 64'(rf_writereg), 64'd3);
        check("t1_writedata", 64'(rf_writedata), 64'h1234);
        check("t1_last_grant", 64'(last_grant), 64'd0);
        tick();
        check("t1_regwrite_off", 64'(rf_regwrite), 64'd0);

        // Both continuously valid: alternate starting from A
        do_reset();
        ai = 1; bi = 11;
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1; a_reg = 5'(ai); a_data = 32'(32'h100 + ai);
            b_valid = 1'b1; b_reg = 5'(bi); b_data = 32'(32'h200 + bi);
            #1;
            check($sformatf("t2_a_ready%0d", i), 64'(a_ready), 64'(exp_a[i]));
            check($sformatf("t2_b_ready%0d", i), 64'(b_ready), 64'(!exp_a[i]));
            tick();
            check($sformatf("t2_writereg%0d", i), 64'(rf_writereg), 64'(exp_reg[i]));
            check($sformatf("t2_writedata%0d", i), 64'(rf_writedata),
                  64'(exp_a[i] ? 32'h100 + exp_reg[i] : 32'h200 + exp_reg[i]));
            check($sformatf("t2_regwrite%0d", i), 64'(rf_regwrite), 64'd1);
            check($sformatf("t2_last_grant%0d", i), 64'(last_grant), 64'(!exp_a[i]));
            if (exp_a[i]) ai++; else bi++;
        end

        // B alone with ptr=0, then both valid: A wins
        a_valid = 1'b0;
        b_valid = 1'b1; b_reg = 5'd5; b_data = 32'd7;
        #1;
        check("t3_b_ready", 64'(b_ready), 64'd1);
        tick();
        check("t3_writereg", 64'(rf_writereg), 64'd5);
        check("t3_writedata", 64'(rf_writedata), 64'd7);
        check("t3_last_grant", 64'(last_grant), 64'd1);
        a_valid = 1'b1; a_reg = 5'd6; a_data = 32'd66;
        b_reg = 5'd8; b_data = 32'd88;
        #1;
        check("t3_both_a_ready", 64'(a_ready), 64'd1);
        check("t3_both_b_ready", 64'(b_ready), 64'd0);
        tick();
        check("t3_both_writereg", 64'(rf_writereg), 64'd6);
        check("t3_both_last_grant", 64'(last_grant), 64'd0);
        a_valid = 1'b0; b_valid = 1'b0;

        // Register-0 writes: consumed, never issued, counted with saturation
        do_reset();
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t4_a_ready%0d", i), 64'(a_ready), 64'd1);
            tick();
            check($sformatf("t4_regwrite%0d", i), 64'(rf_regwrite), 64'd0);
            if (i == 2) begin
                check("t4_drop3", 64'(drop_cnt), 64'd3);
                check("t4_sat_drop3", 64'(s_drop_cnt), 64'd3);
            end
        end
        a_valid = 1'b0;
        check("t4_drop5", 64'(drop_cnt), 64'd5);
        check("t4_sat_drop5", 64'(s_drop_cnt), 64'd3);
        check("t4_writedata", 64'(rf_writedata), 64'hFFFF);

        // Freeze with both valid; ptr=1 after A's last grant
        freeze = 1'b1;
        a_valid = 1'b1; a_reg = 5'd20; a_data = 32'hA0;
        b_valid = 1'b1; b_reg = 5'd21; b_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t5_a_ready%0d", i), 64'(a_ready), 64'd0);
            check($sformatf("t5_b_ready%0d", i), 64'(b_ready), 64'd0);
            tick();
            check($sformatf("t5_regwrite%0d", i), 64'(rf_regwrite), 64'd0);
        end
        check("t5_last_grant", 64'(last_grant), 64'd0);
        freeze = 1'b0;
        #1;
        check("t5_resume_b_ready", 64'(b_ready), 64'd1);
        check("t5_resume_a_ready", 64'(a_ready), 64'd0);
        tick();
        check("t5_resume_writereg", 64'(rf_writereg), 64'd21);
        check("t5_resume_regwrite", 64'(rf_regwrite), 64'd1);
        tick();
        check("t5_next_writereg", 64'(rf_writereg), 64'd20);
        check("t5_next_last_grant", 64'(last_grant), 64'd0);
        b_valid = 1'b0;

        // Grant A reg 9, reset while it sits in the output stage
        a_reg = 5'd9; a_data = 32'h99;
        #1;
        check("t6_a_ready", 64'(a_ready), 64'd1);
        tick();
        a_valid = 1'b0;
        rst = 1'b1;
        check("t6_pre_writereg", 64'(rf_writereg), 64'd9);
        check("t6_pre_regwrite", 64'(rf_regwrite), 64'd1);
        tick();
        rst = 1'b0;
        check("t6_regwrite", 64'(rf_regwrite), 64'd0);
        check("t6_writereg", 64'(rf_writereg), 64'd0);
        check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
        check("t6_sat_drop_cnt", 64'(s_drop_cnt), 64'd0);
        check("t6_last_grant", 64'(last_grant), 64'd1);
        a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h44;
        b_valid = 1'b1; b_reg = 5'd14; b_data = 32'h144;
        #1;
        check("t6_post_a_ready", 64'(a_ready), 64'd1);
        check("t6_post_b_ready", 64'(b_ready), 64'd0);
        tick();
        check("t6_post_writereg", 64'(rf_writereg), 64'd4);
        check("t6_post_last_grant", 64'(last_grant), 64'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
